// File: rtl/textlcd_msg_arbiter_pkg.sv
// Shared types and constants for the text-LCD message arbiter and its helpers.
package textlcd_pkg;

    localparam int MSG_W   = 256;
    localparam int WORD_W  = 32;
    localparam int N_WORDS = MSG_W / WORD_W;

    localparam logic [7:0]        CHAR_SPACE = 8'h20;
    localparam logic [WORD_W-1:0] BLANK_WORD = {4{CHAR_SPACE}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/textlcd_msg_arbiter_if.sv
// Requester-side bus of the text-LCD message arbiter: requests, messages,
// blank command, acks/status and the eight display words for the LCD driver.
interface textlcd_msg_arbiter_if #(
    parameter int N_REQ = 2
) ();
    import textlcd_pkg::*;

    logic [N_REQ-1:0]       req;
    logic [N_REQ*MSG_W-1:0] msg;
    logic                   clr;
    logic [N_REQ-1:0]       ack;
    logic [2:0]             owner;
    logic                   busy;
    logic [WORD_W-1:0]      reg_a;
    logic [WORD_W-1:0]      reg_b;
    logic [WORD_W-1:0]      reg_c;
    logic [WORD_W-1:0]      reg_d;
    logic [WORD_W-1:0]      reg_e;
    logic [WORD_W-1:0]      reg_f;
    logic [WORD_W-1:0]      reg_g;
    logic [WORD_W-1:0]      reg_h;

    modport master (
        output req, msg, clr,
        input  ack, owner, busy,
        input  reg_a, reg_b, reg_c, reg_d, reg_e, reg_f, reg_g, reg_h
    );

    modport slave (
        input  req, msg, clr,
        output ack, owner, busy,
        output reg_a, reg_b, reg_c, reg_d, reg_e, reg_f, reg_g, reg_h
    );

endinterface

// File: rtl/textlcd_msg_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request bit at or above ptr,
// wrapping modulo N_REQ. Reusable for any shared peripheral.
module textlcd_msg_arbiter_rr_pick #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [2:0]       idx,
    output logic             valid
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [2*N_REQ-1:0] req_shift;
    logic [N_REQ-1:0]   req_rot;
    logic [2:0]         off;
    logic [3:0]         sum;

    // Duplicating the vector turns the wrap-around into a plain right shift.
    assign req_dbl   = {req, req};
    assign req_shift = req_dbl >> ptr;
    assign req_rot   = req_shift[N_REQ-1:0];

    always_comb begin
        off   = '0;
        valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                off   = 3'(k);
                valid = 1'b1;
            end
        end
    end

    assign sum = {1'b0, ptr} + {1'b0, off};
    assign idx = (sum >= 4'(N_REQ)) ? 3'(sum - 4'(N_REQ)) : sum[2:0];

endmodule

// File: rtl/textlcd_msg_arbiter.sv
// Round-robin arbiter sharing the 2x16 LCD text registers between N_REQ
// message sources, holding each granted message for HOLD_CYCLES clocks.
module textlcd_msg_arbiter
    import textlcd_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int HOLD_CYCLES = 68000,
    parameter int CNT_W       = 20
) (
    input  logic                  lcdclk,
    input  logic                  reset,
    textlcd_msg_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam int               MSG_SH    = $clog2(MSG_W);

    state_t                          state_reg, state_next;
    logic [2:0]                      gnt_idx_reg, gnt_idx_next;
    logic [2:0]                      rr_ptr_reg, rr_ptr_next;
    logic [2:0]                      owner_reg, owner_next;
    logic [N_REQ-1:0]                ack_reg, ack_next;
    logic                            busy_reg;
    logic [CNT_W-1:0]                cnt_reg, cnt_next;
    logic [N_WORDS-1:0][WORD_W-1:0]  disp_reg, disp_next;

    logic [2:0]       pick_idx;
    logic             pick_valid;
    logic [N_REQ-1:0] gnt_onehot;
    logic [MSG_W-1:0] sel_msg;

    textlcd_msg_arbiter_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (bus.req),
        .ptr   (rr_ptr_reg),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign gnt_onehot[gi] = (gnt_idx_reg == 3'(gi));
        end
    endgenerate

    // Message slices are MSG_W wide, so the slice offset is the index shifted left.
    assign sel_msg = MSG_W'(bus.msg >> {gnt_idx_reg, {MSG_SH{1'b0}}});

    always_comb begin
        state_next   = state_reg;
        gnt_idx_next = gnt_idx_reg;
        rr_ptr_next  = rr_ptr_reg;
        owner_next   = owner_reg;
        ack_next     = '0;
        cnt_next     = cnt_reg;
        disp_next    = disp_reg;

        if (bus.clr) begin
            // Blanking outranks a pending load; the request stays pending.
            disp_next  = {N_WORDS{BLANK_WORD}};
            cnt_next   = HOLD_LOAD;
            state_next = HOLD;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_idx_next = pick_idx;
                        state_next   = GRANT;
                    end
                end
                GRANT: begin
                    disp_next   = sel_msg;
                    ack_next    = gnt_onehot;
                    owner_next  = gnt_idx_reg;
                    rr_ptr_next = (gnt_idx_reg == 3'(N_REQ - 1)) ? 3'd0 : gnt_idx_reg + 3'd1;
                    cnt_next    = HOLD_LOAD;
                    state_next  = HOLD;
                end
                HOLD: begin
                    if (cnt_reg == '0) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge lcdclk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            gnt_idx_reg <= '0;
            rr_ptr_reg  <= '0;
            owner_reg   <= '0;
            ack_reg     <= '0;
            busy_reg    <= 1'b0;
            cnt_reg     <= '0;
            disp_reg    <= {N_WORDS{BLANK_WORD}};
        end else begin
            state_reg   <= state_next;
            gnt_idx_reg <= gnt_idx_next;
            rr_ptr_reg  <= rr_ptr_next;
            owner_reg   <= owner_next;
            ack_reg     <= ack_next;
            busy_reg    <= (state_next != IDLE);
            cnt_reg     <= cnt_next;
            disp_reg    <= disp_next;
        end
    end

    assign bus.ack   = ack_reg;
    assign bus.owner = owner_reg;
    assign bus.busy  = busy_reg;
    assign bus.reg_a = disp_reg[7];
    assign bus.reg_b = disp_reg[6];
    assign bus.reg_c = disp_reg[5];
    assign bus.reg_d = disp_reg[4];
    assign bus.reg_e = disp_reg[3];
    assign bus.reg_f = disp_reg[2];
    assign bus.reg_g = disp_reg[1];
    assign bus.reg_h = disp_reg[0];

endmodule

// File: tb/tb_textlcd_msg_arbiter.sv
// Scoreboard bench for textlcd_msg_arbiter: expected grants (requester, text,
// ack cycle) are queued by the stimulus and checked by an independent monitor.
module tb_textlcd_msg_arbiter;
    import textlcd_pkg::*;

    localparam int N = 2;
    localparam int H = 16;
    localparam logic [255:0] BLANK_ALL = {8{32'h20202020}};

    typedef struct {
        int           idx;
        logic [255:0] msg;
        int           exp_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    exp_t sb[$];
    exp_t mon_e;

    logic [255:0] m [N];
    int           model_ptr;
    int           model_owner;

    logic         rr_mode;
    int           rr_acks;
    int           rr_limit;
    logic [N-1:0] rr_reraise;

    textlcd_msg_arbiter_if #(.N_REQ(N)) bus ();

    textlcd_msg_arbiter #(
        .N_REQ       (N),
        .HOLD_CYCLES (H),
        .CNT_W       (20)
    ) dut (
        .lcdclk (clk),
        .reset  (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] regs_now();
        return {bus.reg_a, bus.reg_b, bus.reg_c, bus.reg_d,
                bus.reg_e, bus.reg_f, bus.reg_g, bus.reg_h};
    endfunction

    // Monitor: every ack must match the oldest expected grant.
    always @(negedge clk) begin
        if (!rst && bus.ack != '0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack=%b at cycle %0d want no ack", bus.ack, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_vector", 256'(bus.ack), 256'(1) << mon_e.idx);
                chk("owner", 256'(bus.owner), 256'(mon_e.idx));
                chk("display_text", regs_now(), mon_e.msg);
                chk("ack_cycle", 256'(cyc), 256'(mon_e.exp_cyc));
                $display("ack req=%0d cycle=%0d text=%h", mon_e.idx, cyc, regs_now());
            end
        end
    end

    // One clock step; emulates requesters dropping req on their ack.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.req    = bus.req | rr_reraise;
        rr_reraise = '0;
        if (bus.ack != '0) begin
            bus.req = bus.req & ~bus.ack;
            if (rr_mode) begin
                rr_reraise = bus.ack;
                rr_acks++;
                if (rr_acks >= rr_limit) begin
                    bus.req    = '0;
                    rr_reraise = '0;
                    rr_mode    = 1'b0;
                end
            end
        end
    endtask

    function automatic int pick_first(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr + k) % N;
            if (mask[c]) return c;
        end
        return 0;
    endfunction

    // Reference: requests pending together are served in rotating order, one
    // every H+2 cycles, starting at the given ack cycle.
    task automatic push_batch(input logic [N-1:0] mask, input int first_cyc);
        logic [N-1:0] pending;
        int           t;
        int           idx;
        pending = mask;
        t       = first_cyc;
        while (pending != '0) begin
            idx = pick_first(pending, model_ptr);
            sb.push_back('{idx, m[idx], t});
            pending[idx] = 1'b0;
            model_ptr    = (idx + 1) % N;
            model_owner  = idx;
            t            = t + H + 2;
        end
    endtask

    task automatic apply_msgs();
        logic [N*256-1:0] all;
        all = '0;
        for (int i = 0; i < N; i++) all[i*256 +: 256] = m[i];
        bus.msg = all;
    endtask

    task automatic rand_msg(input int i);
        for (int w = 0; w < 8; w++) m[i][w*32 +: 32] = $urandom();
    endtask

    task automatic wait_sb(input int budget);
        int k;
        for (k = 0; k < budget && sb.size() != 0; k++) tick();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got %0d acks outstanding want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget && bus.busy; k++) tick();
        if (bus.busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=1 want 0");
        end
    endtask

    task automatic clr_idle_test();
        int bc;
        int ow;
        ow      = model_owner;
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("clr_idle_blank", regs_now(), BLANK_ALL);
        chk("clr_idle_owner", 256'(bus.owner), 256'(ow));
        bc = bus.busy ? 1 : 0;
        for (int k = 0; k < H + 10; k++) begin
            tick();
            if (bus.busy) bc++;
        end
        chk("clr_idle_busy_len", 256'(bc), 256'(H));
    endtask

    initial begin
        int           e;
        int           bc;
        logic [N-1:0] mask;

        total = 0; bad = 0;
        model_ptr = 0; model_owner = 0;
        rr_mode = 1'b0; rr_acks = 0; rr_limit = 0; rr_reraise = '0;
        rst = 1'b1;
        bus.req = '0; bus.clr = 1'b0; bus.msg = '0;
        for (int i = 0; i < N; i++) m[i] = '0;

        repeat (3) tick();
        chk("reset_regs", regs_now(), BLANK_ALL);
        chk("reset_ack", 256'(bus.ack), 256'(0));
        chk("reset_busy", 256'(bus.busy), 256'(0));
        chk("reset_owner", 256'(bus.owner), 256'(0));
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_busy", 256'(bus.busy), 256'(0));

        // Single grant with the reference text.
        m[0] = "Text-LCD ControlSuccess SoC Lab ";
        rand_msg(1);
        apply_msgs();
        push_batch(2'b01, cyc + 2);
        bus.req = 2'b01;
        bc = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.busy) bc++;
            if (k == 1) begin
                chk("single_reg_a", 256'(bus.reg_a), 256'(32'h54657874));
                chk("single_reg_h", 256'(bus.reg_h), 256'(32'h4C616220));
            end
        end
        chk("single_busy_len", 256'(bc), 256'(H + 1));
        wait_sb(5);

        // Request arriving during the hold waits until the hold expires.
        wait_idle(50);
        rand_msg(0);
        rand_msg(1);
        apply_msgs();
        e = cyc + 2;
        push_batch(2'b01, e);
        bus.req = 2'b01;
        repeat (2) tick();
        repeat (3) tick();
        push_batch(2'b10, e + H + 2);
        bus.req = bus.req | 2'b10;
        wait_sb(H + 20);
        wait_idle(50);

        // Random request batches with occasional blanking while idle.
        for (int it = 0; it < 12; it++) begin
            wait_idle(50);
            if ($urandom_range(0, 2) == 0) begin
                clr_idle_test();
                wait_idle(50);
            end
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) rand_msg(i);
            apply_msgs();
            push_batch(mask, cyc + 2);
            bus.req = mask;
            wait_sb(N * (H + 2) + 10);
            wait_idle(50);
        end

        // Blank command in the GRANT cycle beats the load.
        wait_idle(50);
        rand_msg(1);
        apply_msgs();
        bus.req = 2'b10;
        e = cyc;
        tick();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("clr_grant_blank", regs_now(), BLANK_ALL);
        chk("clr_grant_ack", 256'(bus.ack), 256'(0));
        chk("clr_grant_busy", 256'(bus.busy), 256'(1));
        chk("clr_grant_owner", 256'(bus.owner), 256'(model_owner));
        push_batch(2'b10, e + 2 + H + 2);
        wait_sb(H + 20);
        wait_idle(50);

        // Asynchronous reset in the middle of a hold.
        rand_msg(1);
        apply_msgs();
        push_batch(2'b10, cyc + 2);
        bus.req = 2'b10;
        wait_sb(10);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_regs", regs_now(), BLANK_ALL);
        chk("async_reset_ack", 256'(bus.ack), 256'(0));
        chk("async_reset_busy", 256'(bus.busy), 256'(0));
        chk("async_reset_owner", 256'(bus.owner), 256'(0));
        model_ptr = 0;
        model_owner = 0;
        bus.req = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // All requesters keep asking: grants must alternate 0,1,0,1.
        for (int i = 0; i < N; i++) rand_msg(i);
        apply_msgs();
        e = cyc + 2;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = pick_first(2'b11, model_ptr);
            sb.push_back('{idx, m[idx], e + k * (H + 2)});
            model_ptr   = (idx + 1) % N;
            model_owner = idx;
        end
        rr_mode = 1'b1;
        rr_acks = 0;
        rr_limit = 4;
        bus.req = 2'b11;
        wait_sb(4 * (H + 2) + 20);
        wait_idle(50);
        repeat (H + 5) tick();

        chk("scoreboard_drained", 256'(sb.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
